// File: rtl/booth_r4_mult.sv
`default_nettype none
// ============================================================================
// Module   : booth_r4_mult
// Purpose  : Sequential radix-4 Booth multiplier. Retires two multiplier bits
//            per clock and has the same latency for signed and unsigned
//            operands: done/xProd appear ITER+1 edges after start is sampled,
//            where ITER = NBITS/2 + 1.
// Ports    : wClk    - clock, rising edge
//            wRst    - asynchronous active-high reset
//            start   - single-cycle request, honoured only while busy = 0
//            xSigned - 1: both operands two's complement, 0: both unsigned
//            xMpd    - multiplicand (MBITS), captured with start
//            mpr     - multiplier (NBITS), captured with start
//            xProd   - product (MBITS+NBITS), held until the next completion
//            busy    - high while an operation is in flight
//            done    - one-cycle pulse, xProd valid in the same cycle
// Revision : 1.0 - initial release
// ============================================================================
module booth_r4_mult #(
  parameter int MBITS     = 16,
  parameter int NBITS     = 16,
  parameter int COUNTBITS = 4
) (
  input  logic                   wClk,
  input  logic                   wRst,
  input  logic                   start,
  input  logic                   xSigned,
  input  logic [MBITS-1:0]       xMpd,
  input  logic [NBITS-1:0]       mpr,
  output logic [MBITS+NBITS-1:0] xProd,
  output logic                   busy,
  output logic                   done
);

  localparam int ITER = NBITS / 2 + 1;   // Booth digits per product
  localparam int QW   = 2 * ITER;        // extended multiplier width
  localparam int AW   = MBITS + 2;       // holds +-M and +-2M
  localparam int PW   = MBITS + NBITS;   // product width

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           state;
  logic [1:0]           state_next;

  logic [AW-1:0]        mcand;
  logic [AW-1:0]        acc;
  logic [QW-1:0]        q_reg;
  logic                 qm1;
  logic [COUNTBITS-1:0] count;

  logic                 load;
  logic                 step;
  logic                 finish;
  logic                 last_step;

  logic [AW-1:0]        mcand_x2;
  logic [AW-1:0]        digit;
  logic [AW-1:0]        sum;
  logic                 mpd_sign;
  logic                 mpr_sign;
  logic [PW-1:0]        prod_next;

  assign mpd_sign  = xSigned & xMpd[MBITS-1];
  assign mpr_sign  = xSigned & mpr[NBITS-1];
  assign last_step = (count == COUNTBITS'(ITER - 1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge wClk or posedge wRst) begin
    if (wRst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last_step) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state)
      S_IDLE:  load   = start;
      S_RUN:   step   = 1'b1;
      S_DONE:  finish = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Booth digit selection. Partial sums provably stay within [-2M, 2M), so
  // MBITS+2 accumulator bits never overflow, even for unsigned all-ones.
  // --------------------------------------------------------------------------
  assign mcand_x2 = {mcand[AW-2:0], 1'b0};

  always_comb begin
    digit = '0;
    case ({q_reg[1:0], qm1})
      3'b001, 3'b010: digit = mcand;
      3'b011:         digit = mcand_x2;
      3'b100:         digit = '0 - mcand_x2;
      3'b101, 3'b110: digit = '0 - mcand;
      default:        digit = '0;
    endcase
  end

  assign sum = acc + digit;

  // Product is the low PW bits of {acc, q_reg}; PW >= QW always holds.
  generate
    if (PW > QW) begin : g_prod_wide
      assign prod_next = {acc[PW-QW-1:0], q_reg};
    end else begin : g_prod_exact
      assign prod_next = q_reg[PW-1:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Datapath and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge wClk or posedge wRst) begin
    if (wRst) begin
      mcand <= '0;
      acc   <= '0;
      q_reg <= '0;
      qm1   <= 1'b0;
      count <= '0;
      xProd <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        mcand <= {{2{mpd_sign}}, xMpd};
        q_reg <= {{(QW-NBITS){mpr_sign}}, mpr};
        qm1   <= 1'b0;
        acc   <= '0;
        count <= '0;
        busy  <= 1'b1;
      end
      if (step) begin
        // Arithmetic right shift of {acc, q_reg, qm1} by two after the add.
        acc   <= {sum[AW-1], sum[AW-1], sum[AW-1:2]};
        q_reg <= {sum[1:0], q_reg[QW-1:2]};
        qm1   <= q_reg[1];
        count <= count + 1'b1;
      end
      if (finish) begin
        xProd <= prod_next;
        done  <= 1'b1;
        busy  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/booth_r4_mult.md
Name: booth_r4_mult

Overview:
- Sequential radix-4 Booth multiplier; next generation of the team's radix-2 serial multiplier.
- Adds parametrised operand widths (odd NBITS allowed) and a per-operation signed/unsigned mode.
- Retires 2 multiplier bits per cycle, with a fixed latency independent of mode.
- Adds a done pulse and async reset; sits in the filter datapath wherever a coefficient × sample product is needed at sub-sample rate.

Parameters:
- MBITS, 16, multiplicand width (xMpd); any value ≥ 2.
- NBITS, 16, multiplier width (mpr); any value ≥ 2, odd allowed.
- COUNTBITS, 4, iteration counter width; must hold ITER = NBITS/2 + 1 (integer division).

Ports:
- wClk  in  1  clock, rising-edge.
- wRst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only when busy = 0.
- xSigned  in  1  sampled with start; 1 = both operands two's complement, 0 = both unsigned.
- xMpd  in  MBITS  multiplicand; sampled with start.
- mpr  in  NBITS  multiplier; sampled with start.
- xProd  out  MBITS+NBITS  product; held until the next completion.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; xProd is valid in the same cycle.

Behaviour:
- Reset (wRst = 1, asynchronous): state = IDLE; xProd = 0, busy = 0, done = 0, all internal registers = 0. Reset mid-operation aborts it; no done is issued and xProd stays 0.
- Internal widths:
  - Multiplicand register: MBITS+2 bits, sign-extended if xSigned else zero-extended, so that ±M and ±2M are representable.
  - Multiplier register: 2*ITER+1 bits; mpr is sign- or zero-extended to 2*ITER bits, with an appended LSB Booth bit = 0.
  - Accumulator: MBITS+2 bits, signed.
- States:
  - IDLE: busy = 0. On start: capture operands and mode, clear the accumulator, count = 0, busy <= 1, go to RUN.
  - RUN: one Booth digit per edge. Recode the 3 bits {Q[1], Q[0], qm1}:
    - 000 / 111 → 0
    - 001 / 010 → +M
    - 011 → +2M
    - 100 → −2M
    - 101 / 110 → −M
    - Add the digit to the accumulator, then arithmetic-shift {accumulator, Q, qm1} right by 2.
    - count++. After ITER steps, go to DONE.
  - DONE: xProd <= low MBITS+NBITS bits of {accumulator, Q}; done <= 1; busy <= 0; go to IDLE.
- done is deasserted on every edge except the DONE→IDLE edge.
- Latency:
  - start sampled at edge E0; done and xProd visible after edge E0+ITER+1.
  - Default: ITER = 9, so 10 cycles.
  - busy is high after E0 through edge E0+ITER.
- start while busy = 1 (RUN or DONE) is ignored: no capture, no effect on the running operation.
- start in the cycle done = 1 is accepted (busy = 0 then); back-to-back throughput is ITER+2 cycles per product.
- Results are exact with no overflow: unsigned MBITS×NBITS products and signed products fit MBITS+NBITS bits, including the most-negative × most-negative case.
- Inputs are don't-care outside start cycles; changes to xMpd or mpr during RUN do not affect the result.

Test Plan:
- Unsigned, default params: xMpd = 0xFFFF, mpr = 0xFFFF, xSigned = 0 → done exactly 10 cycles after start; xProd = 0xFFFE0001; busy high for cycles 1–9.
- Signed: 0xFFFD × 0x0005 → 0xFFFFFFF1 (−15); 0xFFFF × 0xFFFF → 0x00000001; 0x8000 × 0x8000 → 0x40000000.
- start pulsed again at cycle 4 with different operands → ignored; original product delivered; only one done pulse.
- Back-to-back: second start in the done cycle (7 × 6 after 3 × 4) → xProd = 0x0000000C, then 0x0000002A, with done pulses 11 cycles apart.
- wRst asserted at cycle 5 mid-operation → busy, done, xProd = 0 immediately; no done follows; a new start afterwards completes normally.
- MBITS = 8, NBITS = 5 (ITER = 3), signed: 0x80 × 0x10 → 0x0800 after 4 cycles; unsigned: 0xFF × 0x1F → 0x1EE1.
